// File: rtl/hdr_pkg.sv
// hdr_pkg: shared state encoding and width helpers for the HDR merge/normalise block
package hdr_pkg;

    localparam int PIX_W = 8;

    function automatic int num_w(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int den_w(input int n);
        return n + 2;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int NUM_W = num_w(PIX_W);
    localparam int DEN_W = den_w(PIX_W);
    localparam int CNT_W = cnt_w(PIX_W);

    typedef enum logic [1:0] {IDLE, MAC, DIV, DONE} state_t;

endpackage

// File: rtl/hdr_serial_div.sv
// hdr_serial_div: N-iteration restoring divider producing an N-bit quotient, one bit per cycle
module hdr_serial_div
    import hdr_pkg::*;
#(
    parameter int N     = PIX_W,
    parameter int NUM_W = num_w(N),
    parameter int DEN_W = den_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] dividend_i,
    input  logic [DEN_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N-1:0]     quotient_o
);

    localparam int CNT_W = cnt_w(N);

    logic [DEN_W-1:0] rem_q, rem_d, div_q, div_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DEN_W:0]   trial;
    logic             ge;

    // Upper dividend bits seed the remainder; low bits shift out of quo_q as quotient bits shift in
    always_comb begin
        trial  = {rem_q, quo_q[N-1]};
        ge     = trial >= {1'b0, div_q};
        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i && !busy_q) begin
            rem_d  = dividend_i[NUM_W-1:N];
            quo_d  = dividend_i[N-1:0];
            div_d  = divisor_i;
            cnt_d  = CNT_W'(N);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = ge ? trial[DEN_W-1:0] - div_q : trial[DEN_W-1:0];
            quo_d  = {quo_q[N-2:0], ge};
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = cnt_q != CNT_W'(1);
            done_d = cnt_q == CNT_W'(1);
        end
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/hdr_merge_norm.sv
// hdr_merge_norm: weighted merge of three exposures normalised by the weight sum
module hdr_merge_norm
    import hdr_pkg::*;
#(
    parameter int N     = PIX_W,
    parameter bit ROUND = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] pixel_high,
    input  logic [N-1:0] pixel_mid,
    input  logic [N-1:0] pixel_low,
    input  logic [N-1:0] w_high,
    input  logic [N-1:0] w_mid,
    input  logic [N-1:0] w_low,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pixel_out,
    output logic         div_zero
);

    localparam int NW = num_w(N);
    localparam int DW = den_w(N);

    state_t        state_q, state_d;
    logic [N-1:0]  ph_q, pm_q, pl_q, wh_q, wm_q, wl_q;
    logic [N-1:0]  pixel_out_q, pixel_out_d;
    logic          div_zero_q, div_zero_d, sat_q, sat_d;
    logic [NW-1:0] num;
    logic [DW-1:0] den;
    logic          div_start, div_busy, div_done;
    logic [N-1:0]  quotient;

    // Multiply-accumulate on the captured set, with optional half-denominator bias for rounding
    always_comb begin
        den = DW'(wh_q) + DW'(wm_q) + DW'(wl_q);
        num = NW'(wh_q) * NW'(ph_q) + NW'(wm_q) * NW'(pm_q) + NW'(wl_q) * NW'(pl_q)
            + (ROUND ? NW'(den >> 1) : '0);
    end

    // Capture the input set on the accepting handshake
    always_ff @(posedge clk) begin
        if (rst)
            {ph_q, pm_q, pl_q, wh_q, wm_q, wl_q} <= '0;
        else if (in_valid && state_q == IDLE)
            {ph_q, pm_q, pl_q, wh_q, wm_q, wl_q} <= {pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low};
    end

    assign div_start = state_q == MAC && den != '0 && !div_busy;

    hdr_serial_div #(.N(N), .NUM_W(NW), .DEN_W(DW)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (num),
        .divisor_i  (den),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    // Next state and result; a quotient overflowing N bits (upper dividend >= divisor) saturates
    always_comb begin
        state_d     = state_q;
        pixel_out_d = pixel_out_q;
        div_zero_d  = div_zero_q;
        sat_d       = sat_q;
        case (state_q)
            IDLE: state_d = in_valid ? MAC : IDLE;
            MAC: begin
                sat_d = num[NW-1:N] >= den;
                if (den == '0) begin
                    state_d     = DONE;
                    pixel_out_d = '0;
                    div_zero_d  = 1'b1;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d     = DONE;
                    pixel_out_d = sat_q ? '1 : quotient;
                    div_zero_d  = 1'b0;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pixel_out_q <= '0;
            div_zero_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_out_q <= pixel_out_d;
            div_zero_q  <= div_zero_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign pixel_out = pixel_out_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_hdr_merge_norm.sv
// tb_hdr_merge_norm: scoreboard bench for hdr_merge_norm against an arithmetic reference model
module tb_hdr_merge_norm;

    localparam int N     = 8;
    localparam bit ROUND = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] pixel_out;
    logic         div_zero;

    int           nvec = 0;
    int           errs = 0;
    int           mode = 2;
    logic [N:0]   exp_q[$];

    always #5 clk = ~clk;

    hdr_merge_norm #(.N(N), .ROUND(ROUND)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixel_high (pixel_high),
        .pixel_mid  (pixel_mid),
        .pixel_low  (pixel_low),
        .w_high     (w_high),
        .w_mid      (w_mid),
        .w_low      (w_low),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pixel_out  (pixel_out),
        .div_zero   (div_zero)
    );

    function automatic logic [N:0] ref_out(input int ph, pm, pl, wh, wm, wl);
        int num, den;
        num = wh * ph + wm * pm + wl * pl;
        den = wh + wm + wl;
        if (den == 0) return {1'b1, 8'd0};
        return {1'b0, 8'((num + (ROUND ? den / 2 : 0)) / den)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // out_ready policy: 0 random, 1 held low, 2 held high; changes just after each rising edge
    always @(posedge clk) begin
        #1;
        out_ready = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 2);
    end

    // Monitor: every output handshake pops the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                errs++;
                $display("FAIL unexpected_output: got pixel %0d dz %0b, expected none", pixel_out, div_zero);
            end else begin
                logic [N:0] e;
                e = exp_q.pop_front();
                chk("pixel_out", int'(pixel_out), int'(e[N-1:0]));
                chk("div_zero", int'(div_zero), int'(e[N]));
            end
        end
    end

    task automatic send(input int ph, pm, pl, wh, wm, wl, input logic [N:0] e, input bit push);
        int n = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        pixel_high = 8'(ph);
        pixel_mid  = 8'(pm);
        pixel_low  = 8'(pl);
        w_high     = 8'(wh);
        w_mid      = 8'(wm);
        w_low      = 8'(wl);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++;
            errs++;
            $display("FAIL accept_timeout: in_ready %0b, expected 1", in_ready);
        end else if (push) begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_ref(input int ph, pm, pl, wh, wm, wl);
        send(ph, pm, pl, wh, wm, wl, ref_out(ph, pm, pl, wh, wm, wl), 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            nvec++;
            errs++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ph, pm, pl, wh, wm, wl, n;
        logic [N-1:0] held;
        rst = 1'b1;
        in_valid = 1'b0;
        {pixel_high, pixel_mid, pixel_low, w_high, w_mid, w_low} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_pixel_out", int'(pixel_out), 0);
        chk("reset_div_zero", int'(div_zero), 0);

        // Equal weights, plus exact latency of the normal path
        send(100, 100, 100, 101, 101, 101, {1'b0, 8'd100}, 1'b1);
        repeat (10) @(negedge clk);
        chk("latency_before", int'(out_valid), 0);
        @(negedge clk);
        chk("latency_at", int'(out_valid), 1);
        drain();

        // Rounding case: 16639/130 rounds to 128
        send(255, 128, 0, 1, 128, 1, {1'b0, 8'd128}, 1'b1);
        drain();

        // All-zero weights
        send(37, 200, 9, 0, 0, 0, {1'b1, 8'd0}, 1'b1);
        drain();
        chk("zero_den_idle", int'(in_ready), 1);

        // Backpressure held for 20 cycles with competing input traffic
        mode = 1;
        send_ref(10, 20, 30, 5, 6, 7);
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        held = pixel_out;
        repeat (20) begin
            @(negedge clk);
            in_valid   = 1'b1;
            pixel_high = 8'($urandom_range(0, 255));
            w_high     = 8'($urandom_range(1, 255));
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_pixel_out", int'(pixel_out), int'(held));
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        mode = 2;
        drain();
        chk("bp_release_in_ready", int'(in_ready), 1);
        send_ref(250, 60, 3, 90, 120, 40);
        drain();

        // Reset during the 4th divide cycle aborts the job
        send(200, 150, 100, 30, 40, 50, '0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_pixel_out", int'(pixel_out), 0);
        chk("abort_div_zero", int'(div_zero), 0);
        send_ref(17, 99, 222, 64, 128, 2);
        drain();

        // Random traffic with random backpressure and idle gaps
        mode = 0;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = !in_ready && $urandom_range(0, 1) == 1;
            end
            ph = $urandom_range(0, 255);
            pm = $urandom_range(0, 255);
            pl = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) begin
                wh = 0; wm = 0; wl = 0;
            end else begin
                wh = $urandom_range(0, 255);
                wm = $urandom_range(0, 255);
                wl = $urandom_range(0, 255);
            end
            send_ref(ph, pm, pl, wh, wm, wl);
        end
        mode = 2;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
